// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// prescaler ticks, exposed through an Avalon-MM slave register block.
// Optional build macro PWM_CAPTURE_FILTER_EN inserts a 3-sample majority
// filter after the input synchronizer (rejects 1-clock pulses, +2 clocks latency).
module pwm_capture #(
    parameter int CNT_W        = 32,
    parameter int PRESCALE_RST = 99
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic        avs_chipselect,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        coe_pwm_in
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic              sync1_r, sync2_r, level_s, level_prev_r, rise_s;
    logic              en_r, en_next_s, clr_s;
    logic [15:0]       prescale_r, presc_cnt_r;
    logic              tick_s;
    logic [CNT_W-1:0]  timeout_r, period_cnt_r, high_cnt_r, high_r, period_r;
    logic [CNT_W-1:0]  period_inc_s, high_inc_s;
    logic              tmo_cond_s, latch_s, tmo_evt_s;
    logic              valid_r, overrun_r, tmo_flag_r;
    logic              wr_s, rd_s, ctrl_wr_s, presc_wr_s, stat_wr_s, tmo_wr_s;
    logic [31:0]       rd_mux_s;
    logic              unused_wdata_s;

    assign wr_s       = avs_chipselect & avs_write;
    assign rd_s       = avs_chipselect & avs_read & ~avs_write;
    assign ctrl_wr_s  = wr_s & (avs_address == 4'd0);
    assign presc_wr_s = wr_s & (avs_address == 4'd1);
    assign stat_wr_s  = wr_s & (avs_address == 4'd4);
    assign tmo_wr_s   = wr_s & (avs_address == 4'd5);
    // EN/CLR act in the same clock as the CTRL write so disabling is immediate.
    assign en_next_s  = ctrl_wr_s ? avs_writedata[0] : en_r;
    assign clr_s      = ctrl_wr_s & avs_writedata[1];
    assign unused_wdata_s = ^avs_writedata;

    // Two-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= coe_pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic filt_d1_r, filt_d2_r, filt_r;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over the last three synchronized samples.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            filt_d1_r <= 1'b0;
            filt_d2_r <= 1'b0;
            filt_r    <= 1'b0;
        end else begin
            filt_d1_r <= sync2_r;
            filt_d2_r <= filt_d1_r;
            filt_r    <= majority3(sync2_r, filt_d1_r, filt_d2_r);
        end
    end
    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous level for rising-edge detection on the conditioned input.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            level_prev_r <= 1'b0;
        end else begin
            level_prev_r <= level_s;
        end
    end
    assign rise_s = level_s & ~level_prev_r;

    // Prescaler: one tick every PRESCALE+1 clocks, restarted by a PRESCALE write.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            presc_cnt_r <= 16'd0;
        end else if (presc_wr_s || tick_s) begin
            presc_cnt_r <= 16'd0;
        end else begin
            presc_cnt_r <= presc_cnt_r + 16'd1;
        end
    end
    assign tick_s = (presc_cnt_r == prescale_r);

    // Saturating next values of the running counters, including the current tick.
    always_comb begin
        period_inc_s = period_cnt_r;
        high_inc_s   = high_cnt_r;
        if (tick_s && (period_cnt_r != CNT_MAX)) begin
            period_inc_s = period_cnt_r + CNT_ONE;
        end else begin
            period_inc_s = period_cnt_r;
        end
        if (tick_s && level_s && (high_cnt_r != CNT_MAX)) begin
            high_inc_s = high_cnt_r + CNT_ONE;
        end else begin
            high_inc_s = high_cnt_r;
        end
    end
    assign tmo_cond_s = (timeout_r != CNT_ZERO) && (period_inc_s >= timeout_r);

    // Measurement state register.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and latch/timeout event decode.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        tmo_evt_s    = 1'b0;
        if (!en_next_s) begin
            state_next_s = ST_IDLE;
        end else if (clr_s) begin
            state_next_s = ST_ARM;
        end else begin
            case (state_r)
                ST_IDLE:    state_next_s = ST_ARM;
                ST_ARM:     state_next_s = rise_s ? ST_MEASURE : ST_ARM;
                ST_MEASURE: begin
                    if (rise_s) begin
                        latch_s      = 1'b1;
                        state_next_s = ST_MEASURE;
                    end else if (tmo_cond_s) begin
                        tmo_evt_s    = 1'b1;
                        state_next_s = ST_ARM;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // Running counters and the latched HIGH/PERIOD results.
    always_ff @(posedge csi_clk) begin
        if (csi_reset || clr_s) begin
            high_cnt_r   <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
            high_r       <= CNT_ZERO;
            period_r     <= CNT_ZERO;
        end else if (latch_s) begin
            high_r       <= high_inc_s;
            period_r     <= period_inc_s;
            high_cnt_r   <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
        end else if (tmo_evt_s) begin
            high_r       <= level_s ? period_inc_s : CNT_ZERO;
            period_r     <= CNT_ZERO;
            high_cnt_r   <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_MEASURE) && (state_next_s == ST_MEASURE)) begin
            high_cnt_r   <= high_inc_s;
            period_cnt_r <= period_inc_s;
        end else begin
            high_cnt_r   <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
        end
    end

    // Sticky status flags: set events win over write-1-to-clear.
    always_ff @(posedge csi_clk) begin
        if (csi_reset || clr_s) begin
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
            tmo_flag_r <= 1'b0;
        end else begin
            valid_r    <= (valid_r    & ~(stat_wr_s & avs_writedata[0])) | latch_s;
            overrun_r  <= (overrun_r  & ~(stat_wr_s & avs_writedata[1])) | (latch_s & valid_r);
            tmo_flag_r <= (tmo_flag_r & ~(stat_wr_s & avs_writedata[2])) | tmo_evt_s;
        end
    end

    // Writable configuration registers.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            en_r       <= 1'b0;
            prescale_r <= 16'(PRESCALE_RST);
            timeout_r  <= CNT_ZERO;
        end else begin
            if (ctrl_wr_s)  en_r       <= avs_writedata[0];
            if (presc_wr_s) prescale_r <= avs_writedata[15:0];
            if (tmo_wr_s)   timeout_r  <= avs_writedata[CNT_W-1:0];
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            4'd0: rd_mux_s[0]         = en_r;
            4'd1: rd_mux_s[15:0]      = prescale_r;
            4'd2: rd_mux_s[CNT_W-1:0] = high_r;
            4'd3: rd_mux_s[CNT_W-1:0] = period_r;
            4'd4: rd_mux_s[3:0]       = {level_s, tmo_flag_r, overrun_r, valid_r};
            4'd5: rd_mux_s[CNT_W-1:0] = timeout_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            avs_readdata <= 32'd0;
        end else if (rd_s) begin
            avs_readdata <= rd_mux_s;
        end else begin
            avs_readdata <= avs_readdata;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture.
module tb_pwm_capture;

    logic        csi_clk = 1'b0;
    logic        csi_reset = 1'b1;
    logic        avs_chipselect = 1'b0;
    logic [3:0]  avs_address = 4'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        coe_pwm_in = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    pwm_capture dut (
        .csi_clk        (csi_clk),
        .csi_reset      (csi_reset),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .coe_pwm_in     (coe_pwm_in)
    );

    always #5 csi_clk = ~csi_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge csi_clk);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge csi_clk);
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge csi_clk);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
        @(negedge csi_clk);
        avs_chipselect = 1'b0; avs_read = 1'b0;
        d = avs_readdata;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge csi_clk);
        check("readdata_in_reset", avs_readdata, 32'd0);
        csi_reset = 1'b0;
        bus_read(4'd0, rd); check("rst_ctrl", rd, 32'd0);
        bus_read(4'd1, rd); check("rst_prescale", rd, 32'd99);
        bus_read(4'd2, rd); check("rst_high", rd, 32'd0);
        bus_read(4'd3, rd); check("rst_period", rd, 32'd0);
        bus_read(4'd4, rd); check("rst_status", rd, 32'd0);
        bus_read(4'd5, rd); check("rst_timeout", rd, 32'd0);
        bus_read(4'd9, rd); check("unmapped_read", rd, 32'd0);

        // 30% duty, period 1000 ticks at PRESCALE=9 (10000 clocks)
        bus_write(4'd1, 32'd9);
        bus_write(4'd0, 32'd1);
        repeat (20) @(negedge csi_clk);
        bus_read(4'd4, rd); check("armed_status", rd, 32'd0);
        coe_pwm_in = 1'b1;
        repeat (3000) @(negedge csi_clk);
        coe_pwm_in = 1'b0;
        repeat (7000) @(negedge csi_clk);
        coe_pwm_in = 1'b1;
        repeat (8) @(negedge csi_clk);
        bus_read(4'd2, rd); check("pwm_high", rd, 32'd300);
        bus_read(4'd3, rd); check("pwm_period", rd, 32'd1000);
        bus_read(4'd4, rd); check("pwm_status_valid", rd, 32'h9);
        repeat (2986) @(negedge csi_clk);
        coe_pwm_in = 1'b0;
        repeat (7000) @(negedge csi_clk);
        coe_pwm_in = 1'b1;
        repeat (8) @(negedge csi_clk);
        bus_read(4'd4, rd); check("overrun_status", rd, 32'hB);
        bus_read(4'd2, rd); check("pwm_high_2", rd, 32'd300);
        bus_read(4'd3, rd); check("pwm_period_2", rd, 32'd1000);
        bus_write(4'd4, 32'h3);
        bus_read(4'd4, rd); check("w1c_status", rd, 32'h8);
        coe_pwm_in = 1'b0;

        // Timeout: TIMEOUT=500 ticks at PRESCALE=3, input held high
        bus_write(4'd0, 32'd0);
        bus_read(4'd0, rd); check("ctrl_disabled", rd, 32'd0);
        bus_write(4'd1, 32'd3);
        bus_write(4'd5, 32'd500);
        bus_write(4'd4, 32'h7);
        bus_write(4'd0, 32'd1);
        repeat (20) @(negedge csi_clk);
        coe_pwm_in = 1'b1;
        repeat (1900) @(negedge csi_clk);
        bus_read(4'd4, rd); check("pre_timeout_status", rd, 32'h8);
        repeat (200) @(negedge csi_clk);
        bus_read(4'd4, rd); check("timeout_status", rd, 32'hC);
        bus_read(4'd2, rd); check("timeout_high", rd, 32'd500);
        bus_read(4'd3, rd); check("timeout_period", rd, 32'd0);

        // CLR with EN kept set
        bus_write(4'd0, 32'd3);
        bus_read(4'd0, rd); check("clr_selfclear", rd, 32'd1);
        bus_read(4'd2, rd); check("clr_high", rd, 32'd0);
        bus_read(4'd4, rd); check("clr_status", rd, 32'h8);

        // Read and write together on PRESCALE
        bus_read(4'd0, rd); check("rw_pre_read", rd, 32'd1);
        @(negedge csi_clk);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
        avs_address = 4'd1; avs_writedata = 32'd5;
        @(negedge csi_clk);
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        check("rw_readdata_held", avs_readdata, 32'd1);
        bus_read(4'd1, rd); check("rw_prescale", rd, 32'd5);

        // One-clock glitch while measuring
        coe_pwm_in = 1'b0;
        repeat (10) @(negedge csi_clk);
        coe_pwm_in = 1'b1;
        repeat (10) @(negedge csi_clk);
        coe_pwm_in = 1'b0;
        repeat (20) @(negedge csi_clk);
        bus_read(4'd4, rd); check("pre_glitch_status", rd, 32'h0);
        @(negedge csi_clk); coe_pwm_in = 1'b1;
        @(negedge csi_clk); coe_pwm_in = 1'b0;
        repeat (10) @(negedge csi_clk);
        bus_read(4'd4, rd);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch_status", rd, 32'h0);
`else
        check("glitch_status", rd, 32'h1);
`endif

        // Reset mid-period
        coe_pwm_in = 1'b1;
        repeat (10) @(negedge csi_clk);
        coe_pwm_in = 1'b0;
        repeat (5) @(negedge csi_clk);
        bus_read(4'd1, rd); check("pre_reset_read", rd, 32'd5);
        @(negedge csi_clk); csi_reset = 1'b1;
        @(negedge csi_clk); csi_reset = 1'b0;
        check("readdata_after_reset", avs_readdata, 32'd0);
        bus_read(4'd0, rd); check("mid_rst_ctrl", rd, 32'd0);
        bus_read(4'd1, rd); check("mid_rst_prescale", rd, 32'd99);
        bus_read(4'd2, rd); check("mid_rst_high", rd, 32'd0);
        bus_read(4'd3, rd); check("mid_rst_period", rd, 32'd0);
        bus_read(4'd4, rd); check("mid_rst_status", rd, 32'd0);
        bus_read(4'd5, rd); check("mid_rst_timeout", rd, 32'd0);
        repeat (20) @(negedge csi_clk);
        bus_read(4'd4, rd); check("post_rst_idle_status", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
